// File: rtl/instr_fetch.sv
// instr_fetch: BOOT/RUN/HALT fetch sequencer for a dual-port instruction RAM.
//   clk, reset_n           : clock, asynchronous active-low reset
//   instr_addr1/instr_addr2: next instruction / operand addresses from the decoder
//   new_pc, pc_sload       : pc load value and load strobe
//   cnt_en, stall, start   : pc increment, pipeline freeze, restart from HALT
//   mem_q_a/mem_q_b        : registered RAM read data (ports A/B)
//   mem_addr_a/mem_addr_b  : RAM addresses (ports A/B)
//   instr, N, pc, valid    : current instruction, operand, next-word pc, executable flag
//   halted, instr_count    : HALT indicator, saturating executed-instruction count
module instr_fetch (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr_addr1,
    input  logic [15:0] instr_addr2,
    input  logic [15:0] new_pc,
    input  logic        pc_sload,
    input  logic        cnt_en,
    input  logic        stall,
    input  logic        start,
    input  logic [15:0] mem_q_a,
    input  logic [15:0] mem_q_b,
    output logic [15:0] mem_addr_a,
    output logic [15:0] mem_addr_b,
    output logic [15:0] instr,
    output logic [15:0] N,
    output logic [15:0] pc,
    output logic        valid,
    output logic        halted,
    output logic [15:0] instr_count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_pc, r_held_a, r_held_b, r_cnt;
    logic        w_valid, w_stp, w_adv, w_restart;

    assign w_valid   = (r_state == RUN) && !stall;
    assign w_stp     = w_valid && (mem_q_a[15:11] == 5'b11111);
    // a STP cycle still counts but leaves pc and held addresses pointing at the STP word
    assign w_adv     = w_valid && !w_stp;
    assign w_restart = (r_state == HALT) && start;

    always_comb begin
        w_next = r_state;
        if (r_state == BOOT)
            w_next = RUN;
        else if (w_stp)
            w_next = HALT;
        else if (w_restart)
            w_next = BOOT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= BOOT;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= 16'h0001;
            r_held_a <= 16'h0000;
            r_held_b <= 16'h0001;
            r_cnt    <= 16'h0000;
        end else begin
            // BOOT reloads the held addresses so a stall on the first RUN cycle re-reads 0/1
            if (r_state == BOOT) begin
                r_held_a <= 16'h0000;
                r_held_b <= 16'h0001;
            end else if (w_adv) begin
                r_held_a <= instr_addr1;
                r_held_b <= instr_addr2;
            end
            if (w_adv)
                r_pc <= pc_sload ? new_pc : cnt_en ? r_pc + 16'd1 : r_pc;
            else if (w_restart)
                r_pc <= 16'h0001;
            if (w_valid && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
            else if (w_restart)
                r_cnt <= 16'h0000;
        end
    end

    assign mem_addr_a  = (r_state == BOOT) ? 16'h0000 : w_valid ? instr_addr1 : r_held_a;
    assign mem_addr_b  = (r_state == BOOT) ? 16'h0001 : w_valid ? instr_addr2 : r_held_b;
    assign instr       = mem_q_a;
    assign N           = mem_q_b;
    assign pc          = r_pc;
    assign valid       = w_valid;
    assign halted      = (r_state == HALT);
    assign instr_count = r_cnt;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven check of instr_fetch against a registered-read RAM model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instr_addr1 = 16'h0, instr_addr2 = 16'h0, new_pc = 16'h0;
    logic        pc_sload = 1'b0, cnt_en = 1'b0, stall = 1'b0, start = 1'b0;
    logic [15:0] mem_q_a = 16'h0, mem_q_b = 16'h0;
    logic [15:0] mem_addr_a, mem_addr_b, instr, N, pc, instr_count;
    logic        valid, halted;
    logic [15:0] ram [0:255];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        st, ld, ce, go;
        logic [15:0] np, a1, a2;
        logic        ev, eh;
        logic [15:0] ema, emb, ei, en, epc, ecnt;
        logic        cd;
    } vec_t;

    vec_t v [19];

    instr_fetch dut (
        .clk(clk), .reset_n(reset_n), .instr_addr1(instr_addr1), .instr_addr2(instr_addr2),
        .new_pc(new_pc), .pc_sload(pc_sload), .cnt_en(cnt_en), .stall(stall), .start(start),
        .mem_q_a(mem_q_a), .mem_q_b(mem_q_b), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .instr(instr), .N(N), .pc(pc), .valid(valid), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_q_a <= ram[mem_addr_a[7:0]];
        mem_q_b <= ram[mem_addr_b[7:0]];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h1100 + 16'(i);
        ram[0]     = 16'h0000;
        ram[1]     = 16'h1234;
        ram[8'h30] = 16'hF800;

        //        st ld ce go  np        a1        a2      ev eh  ema       emb       ei        en        epc       ecnt     cd
        v[0]  = '{0, 0, 1, 0, 16'h0000, 16'h0010, 16'h0011, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0};
        v[1]  = '{0, 0, 1, 0, 16'h0000, 16'h0002, 16'h0003, 1, 0, 16'h0002, 16'h0003, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 1};
        v[2]  = '{0, 1, 1, 0, 16'h0040, 16'h0040, 16'h0041, 1, 0, 16'h0040, 16'h0041, 16'h1102, 16'h1103, 16'h0002, 16'h0001, 1};
        v[3]  = '{0, 0, 1, 0, 16'h0000, 16'h0041, 16'h0042, 1, 0, 16'h0041, 16'h0042, 16'h1140, 16'h1141, 16'h0040, 16'h0002, 1};
        v[4]  = '{1, 1, 1, 0, 16'h9999, 16'h0077, 16'h0078, 0, 0, 16'h0041, 16'h0042, 16'h1141, 16'h1142, 16'h0041, 16'h0003, 1};
        v[5]  = v[4];
        v[6]  = v[4];
        v[7]  = '{0, 0, 0, 0, 16'h0000, 16'h0043, 16'h0044, 1, 0, 16'h0043, 16'h0044, 16'h1141, 16'h1142, 16'h0041, 16'h0003, 1};
        v[8]  = '{0, 0, 1, 0, 16'h0000, 16'h0030, 16'h0031, 1, 0, 16'h0030, 16'h0031, 16'h1143, 16'h1144, 16'h0041, 16'h0004, 1};
        v[9]  = '{1, 0, 1, 0, 16'h0000, 16'h0050, 16'h0051, 0, 0, 16'h0030, 16'h0031, 16'hF800, 16'h1131, 16'h0042, 16'h0005, 1};
        v[10] = '{0, 1, 1, 0, 16'h5555, 16'h0050, 16'h0051, 1, 0, 16'h0050, 16'h0051, 16'hF800, 16'h1131, 16'h0042, 16'h0005, 1};
        v[11] = '{0, 1, 1, 0, 16'h7777, 16'h0060, 16'h0061, 0, 1, 16'h0030, 16'h0031, 16'h1150, 16'h1151, 16'h0042, 16'h0006, 1};
        v[12] = '{0, 1, 1, 0, 16'h7777, 16'h0060, 16'h0061, 0, 1, 16'h0030, 16'h0031, 16'hF800, 16'h1131, 16'h0042, 16'h0006, 1};
        v[13] = '{1, 1, 1, 1, 16'h7777, 16'h0060, 16'h0061, 0, 1, 16'h0030, 16'h0031, 16'hF800, 16'h1131, 16'h0042, 16'h0006, 1};
        v[14] = '{0, 0, 1, 1, 16'h0000, 16'h0010, 16'h0011, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h1131, 16'h0001, 16'h0000, 1};
        v[15] = '{0, 0, 1, 1, 16'h0000, 16'h0002, 16'h0003, 1, 0, 16'h0002, 16'h0003, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 1};
        v[16] = '{0, 1, 0, 0, 16'hFFFF, 16'h0004, 16'h0005, 1, 0, 16'h0004, 16'h0005, 16'h1102, 16'h1103, 16'h0002, 16'h0001, 1};
        v[17] = '{0, 0, 1, 0, 16'h0000, 16'h0006, 16'h0007, 1, 0, 16'h0006, 16'h0007, 16'h1104, 16'h1105, 16'hFFFF, 16'h0002, 1};
        v[18] = '{0, 0, 0, 0, 16'h0000, 16'h0008, 16'h0009, 1, 0, 16'h0008, 16'h0009, 16'h1106, 16'h1107, 16'h0000, 16'h0003, 1};

        // reset values while reset_n is held low
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_pc", pc, 16'h0001);
        chk("rst_cnt", instr_count, 16'h0000);
        chk("rst_addr_a", mem_addr_a, 16'h0000);
        chk("rst_addr_b", mem_addr_b, 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            stall = v[i].st; pc_sload = v[i].ld; cnt_en = v[i].ce; start = v[i].go;
            new_pc = v[i].np; instr_addr1 = v[i].a1; instr_addr2 = v[i].a2;
            #1;
            chk($sformatf("v%0d_valid", i), 16'(valid), 16'(v[i].ev));
            chk($sformatf("v%0d_halted", i), 16'(halted), 16'(v[i].eh));
            chk($sformatf("v%0d_addr_a", i), mem_addr_a, v[i].ema);
            chk($sformatf("v%0d_addr_b", i), mem_addr_b, v[i].emb);
            chk($sformatf("v%0d_pc", i), pc, v[i].epc);
            chk($sformatf("v%0d_cnt", i), instr_count, v[i].ecnt);
            if (v[i].cd) begin
                chk($sformatf("v%0d_instr", i), instr, v[i].ei);
                chk($sformatf("v%0d_N", i), N, v[i].en);
            end
            @(negedge clk);
        end

        // asynchronous reset between clock edges, mid-RUN
        stall = 1'b0; pc_sload = 1'b0; cnt_en = 1'b0; start = 1'b0;
        instr_addr1 = 16'h0002; instr_addr2 = 16'h0003;
        #1;
        chk("pre_arst_valid", 16'(valid), 16'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", 16'(valid), 16'h0);
        chk("arst_halted", 16'(halted), 16'h0);
        chk("arst_pc", pc, 16'h0001);
        chk("arst_cnt", instr_count, 16'h0000);
        chk("arst_addr_a", mem_addr_a, 16'h0000);
        chk("arst_addr_b", mem_addr_b, 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("boot_valid", 16'(valid), 16'h0);
        @(posedge clk);
        #1;
        chk("run_valid", 16'(valid), 16'h1);

        // saturation of the executed-instruction counter
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_fffe", instr_count, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("cnt_ffff", instr_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_sat", instr_count, 16'hFFFF);
        chk("sat_valid", 16'(valid), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
